// File: rtl/nes_mem_pkg.sv
// Shared types for the NES cartridge memory arbiter.
package nes_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 22;
  localparam int unsigned MEM_DATA_W = 8;
  localparam int unsigned TIMEOUT_W  = 8;

  typedef enum logic {
    SRC_PRG = 1'b0,
    SRC_CHR = 1'b1
  } src_e;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/nes_mem_slot.sv
// Per-source request slot: allow filtering, pending/in-flight registers,
// overrun detection, read-data register and done pulse.
module nes_mem_slot
  import nes_mem_pkg::*;
#(
  parameter bit READ_GATED = 1'b1  // 1: reads also need allow_i (PRG); 0: reads always allowed (CHR)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [MEM_ADDR_W-1:0] addr_i,
  input  logic                  allow_i,
  input  logic [MEM_DATA_W-1:0] din_i,
  output logic                  offer_valid_o,
  input  logic                  grant_i,
  output mem_req_t              inflight_o,
  input  logic                  complete_i,
  input  logic                  ack_i,
  input  logic [MEM_DATA_W-1:0] rdata_i,
  output logic [MEM_DATA_W-1:0] dout_o,
  output logic                  done_o,
  output logic                  overrun_o
);

  logic                  cap_valid;
  logic                  drop;
  mem_req_t              cap_req;
  mem_req_t              offer;
  logic                  pend_valid_d, pend_valid_q;
  mem_req_t              pend_d, pend_q;
  mem_req_t              inflight_d, inflight_q;
  logic [MEM_DATA_W-1:0] dout_d, dout_q;
  logic                  done_d, done_q;

  // Classify this cycle's strobe: capture as a request or answer locally.
  always_comb begin
    cap_valid     = 1'b0;
    drop          = 1'b0;
    cap_req.we    = write_i;
    cap_req.addr  = addr_i;
    cap_req.wdata = din_i;
    if (write_i) begin
      // Write wins if both strobes arrive together.
      if (allow_i) cap_valid = 1'b1;
      else         drop      = 1'b1;
    end else if (read_i) begin
      if (allow_i || !READ_GATED) cap_valid = 1'b1;
      else                        drop      = 1'b1;
    end
  end

  // An idle arbiter may take a fresh strobe straight to in-flight.
  assign offer_valid_o = pend_valid_q | cap_valid;
  assign offer         = pend_valid_q ? pend_q : cap_req;

  // Next state of pending/in-flight, dout and done.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    inflight_d   = inflight_q;
    overrun_o    = 1'b0;
    if (grant_i) begin
      inflight_d = offer;
      // If the pending entry was granted, a new strobe refills it.
      if (pend_valid_q) begin
        pend_valid_d = cap_valid;
        if (cap_valid) pend_d = cap_req;
      end
    end else if (cap_valid) begin
      overrun_o    = pend_valid_q;
      pend_valid_d = 1'b1;
      pend_d       = cap_req;
    end
    dout_d = dout_q;
    if (complete_i && ack_i && !inflight_q.we) dout_d = rdata_i;
    done_d = drop | complete_i;
  end

  // Slot state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      inflight_q   <= '0;
      dout_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      inflight_q   <= inflight_d;
      dout_q       <= dout_d;
      done_q       <= done_d;
    end
  end

  assign inflight_o = inflight_q;
  assign dout_o     = dout_q;
  assign done_o     = done_q;

endmodule

// File: rtl/nes_mem_arbiter.sv
// Serialises mapper-translated PRG and CHR accesses onto one req/ack memory port.
module nes_mem_arbiter
  import nes_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = MEM_ADDR_W,
  parameter int unsigned DATA_W    = MEM_DATA_W,
  parameter int unsigned TIMEOUT   = 255,
  parameter bit          CHR_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              prg_read_i,
  input  logic              prg_write_i,
  input  logic [ADDR_W-1:0] prg_aout_i,
  input  logic              prg_allow_i,
  input  logic [DATA_W-1:0] prg_din_i,
  output logic [DATA_W-1:0] prg_dout_o,
  output logic              prg_done_o,
  input  logic              chr_read_i,
  input  logic              chr_write_i,
  input  logic [ADDR_W-1:0] chr_aout_i,
  input  logic              chr_allow_i,
  input  logic [DATA_W-1:0] chr_din_i,
  output logic [DATA_W-1:0] chr_dout_o,
  output logic              chr_done_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_overrun_o,
  output logic              err_timeout_o
);

  localparam logic [TIMEOUT_W-1:0] TmoLimit = TIMEOUT_W'(TIMEOUT);

  arb_state_e           state_d, state_q;
  src_e                 src_d, src_q;
  src_e                 last_grant_d, last_grant_q;
  src_e                 sel_src;
  logic [TIMEOUT_W-1:0] tmo_cnt_d, tmo_cnt_q, tmo_inc;
  logic                 err_overrun_q, err_timeout_q;
  logic                 prg_offer, chr_offer;
  logic                 grant_prg, grant_chr;
  logic                 ack_hit, tmo_hit;
  logic                 complete_prg, complete_chr;
  logic                 prg_overrun, chr_overrun;
  mem_req_t             prg_inflight, chr_inflight, req_mux;

  nes_mem_slot #(.READ_GATED(1'b1)) u_prg_slot (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .read_i        (prg_read_i),
    .write_i       (prg_write_i),
    .addr_i        (prg_aout_i),
    .allow_i       (prg_allow_i),
    .din_i         (prg_din_i),
    .offer_valid_o (prg_offer),
    .grant_i       (grant_prg),
    .inflight_o    (prg_inflight),
    .complete_i    (complete_prg),
    .ack_i         (ack_hit),
    .rdata_i       (mem_rdata_i),
    .dout_o        (prg_dout_o),
    .done_o        (prg_done_o),
    .overrun_o     (prg_overrun)
  );

  nes_mem_slot #(.READ_GATED(1'b0)) u_chr_slot (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .read_i        (chr_read_i),
    .write_i       (chr_write_i),
    .addr_i        (chr_aout_i),
    .allow_i       (chr_allow_i),
    .din_i         (chr_din_i),
    .offer_valid_o (chr_offer),
    .grant_i       (grant_chr),
    .inflight_o    (chr_inflight),
    .complete_i    (complete_chr),
    .ack_i         (ack_hit),
    .rdata_i       (mem_rdata_i),
    .dout_o        (chr_dout_o),
    .done_o        (chr_done_o),
    .overrun_o     (chr_overrun)
  );

  // Round-robin pick: under contention, grant whoever did not win last.
  always_comb begin
    sel_src = SRC_PRG;
    if (prg_offer && chr_offer) sel_src = (last_grant_q == SRC_PRG) ? SRC_CHR : SRC_PRG;
    else if (chr_offer)         sel_src = SRC_CHR;
  end

  // Saturating timeout increment and abort condition.
  always_comb begin
    tmo_inc = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    ack_hit = (state_q == ARB_BUSY) && mem_ack_i;
    tmo_hit = (state_q == ARB_BUSY) && !mem_ack_i && (tmo_inc == TmoLimit);
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ARB_IDLE;
      src_q         <= SRC_PRG;
      last_grant_q  <= CHR_FIRST ? SRC_PRG : SRC_CHR;
      tmo_cnt_q     <= '0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      last_grant_q  <= last_grant_d;
      tmo_cnt_q     <= tmo_cnt_d;
      err_overrun_q <= err_overrun_q | prg_overrun | chr_overrun;
      err_timeout_q <= err_timeout_q | tmo_hit;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    tmo_cnt_d    = tmo_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (prg_offer || chr_offer) begin
          src_d        = sel_src;
          last_grant_d = sel_src;
          tmo_cnt_d    = '0;
          state_d      = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (mem_ack_i || tmo_hit) state_d   = ARB_IDLE;
        else                      tmo_cnt_d = tmo_inc;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: grants, completions and the memory port mux.
  always_comb begin
    grant_prg    = (state_q == ARB_IDLE) && (prg_offer || chr_offer) && (sel_src == SRC_PRG);
    grant_chr    = (state_q == ARB_IDLE) && (prg_offer || chr_offer) && (sel_src == SRC_CHR);
    complete_prg = (ack_hit || tmo_hit) && (src_q == SRC_PRG);
    complete_chr = (ack_hit || tmo_hit) && (src_q == SRC_CHR);
    req_mux      = (src_q == SRC_PRG) ? prg_inflight : chr_inflight;
    mem_req_o    = (state_q == ARB_BUSY);
    mem_we_o     = req_mux.we;
    mem_addr_o   = req_mux.addr;
    mem_wdata_o  = req_mux.wdata;
  end

  assign err_overrun_o = err_overrun_q;
  assign err_timeout_o = err_timeout_q;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Directed self-checking bench for nes_mem_arbiter.
module tb_nes_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        prg_read, prg_write, prg_allow;
  logic [21:0] prg_aout;
  logic [7:0]  prg_din;
  logic [7:0]  prg_dout;
  logic        prg_done;
  logic        chr_read, chr_write, chr_allow;
  logic [21:0] chr_aout;
  logic [7:0]  chr_din;
  logic [7:0]  chr_dout;
  logic        chr_done;
  logic        mem_req, mem_we, mem_ack;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        err_overrun, err_timeout;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_prg_dout;

  nes_mem_arbiter #(
    .ADDR_W    (22),
    .DATA_W    (8),
    .TIMEOUT   (255),
    .CHR_FIRST (1'b1)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .prg_read_i    (prg_read),
    .prg_write_i   (prg_write),
    .prg_aout_i    (prg_aout),
    .prg_allow_i   (prg_allow),
    .prg_din_i     (prg_din),
    .prg_dout_o    (prg_dout),
    .prg_done_o    (prg_done),
    .chr_read_i    (chr_read),
    .chr_write_i   (chr_write),
    .chr_aout_i    (chr_aout),
    .chr_allow_i   (chr_allow),
    .chr_din_i     (chr_din),
    .chr_dout_o    (chr_dout),
    .chr_done_o    (chr_done),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata),
    .err_overrun_o (err_overrun),
    .err_timeout_o (err_timeout)
  );

  initial forever #5 clk = ~clk;

  // Read and write strobes from one source must never coincide.
  always @(posedge clk) begin
    assert (!(prg_read && prg_write)) else $error("prg read and write strobed together");
    assert (!(chr_read && chr_write)) else $error("chr read and write strobed together");
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_vec++;
    if ({prg_dout, prg_done, chr_dout, chr_done, mem_req, mem_we, mem_addr, mem_wdata,
         err_overrun, err_timeout} !== 52'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0", {prg_dout, prg_done, chr_dout, chr_done,
               mem_req, mem_we, mem_addr, mem_wdata, err_overrun, err_timeout});
    end
    reset = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({mem_req, prg_done, chr_done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_idle: got %b required 000", {mem_req, prg_done, chr_done});
    end
  endtask

  task automatic test_prg_read();
    prg_aout = 22'h01E123; prg_allow = 1'b1; prg_read = 1'b1;
    tick();
    prg_read = 1'b0;
    n_vec++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 22'h01E123}) begin
      n_bad++;
      $display("FAIL prg_read_req: got req=%b we=%b addr=%h required 1 0 01e123",
               mem_req, mem_we, mem_addr);
    end
    tick();
    tick();
    n_vec++;
    if ({mem_req, prg_done} !== 2'b10) begin
      n_bad++;
      $display("FAIL prg_read_wait: got req,done=%b required 10", {mem_req, prg_done});
    end
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    n_vec++;
    if ({mem_req, prg_done, prg_dout} !== {1'b0, 1'b1, 8'h5A}) begin
      n_bad++;
      $display("FAIL prg_read_done: got req=%b done=%b dout=%h required 0 1 5a",
               mem_req, prg_done, prg_dout);
    end
    tick();
    n_vec++;
    if (prg_done !== 1'b0) begin
      n_bad++;
      $display("FAIL prg_done_pulse: got %b required 0", prg_done);
    end
  endtask

  task automatic test_prg_write();
    prg_aout = 22'h006001; prg_din = 8'hC3; prg_write = 1'b1;
    tick();
    prg_write = 1'b0;
    n_vec++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 22'h006001, 8'hC3}) begin
      n_bad++;
      $display("FAIL prg_write_req: got req=%b we=%b addr=%h wdata=%h required 1 1 006001 c3",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    n_vec++;
    if ({prg_done, prg_dout} !== {1'b1, 8'h5A}) begin
      n_bad++;
      $display("FAIL prg_write_done: got done=%b dout=%h required 1 5a", prg_done, prg_dout);
    end
    tick();
  endtask

  task automatic test_disallowed();
    logic seen;
    chr_aout = 22'h000100; chr_din = 8'hAB; chr_allow = 1'b0; chr_write = 1'b1;
    tick();
    chr_write = 1'b0;
    n_vec++;
    if ({chr_done, mem_req} !== 2'b10) begin
      n_bad++;
      $display("FAIL chr_wr_denied: got done,req=%b required 10", {chr_done, mem_req});
    end
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (mem_req || chr_done) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL chr_wr_denied_quiet: got activity=%b required 0", seen);
    end
    chr_allow = 1'b1;
    // Establish a known PRG dout of 0x33.
    prg_aout = 22'h000456; prg_allow = 1'b1; prg_read = 1'b1;
    tick();
    prg_read = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h33;
    tick();
    mem_ack = 1'b0;
    n_vec++;
    if ({prg_done, prg_dout} !== {1'b1, 8'h33}) begin
      n_bad++;
      $display("FAIL prg_prime: got done=%b dout=%h required 1 33", prg_done, prg_dout);
    end
    tick();
    prg_allow = 1'b0; prg_read = 1'b1; mem_rdata = 8'h99;
    tick();
    prg_read = 1'b0; prg_allow = 1'b1;
    n_vec++;
    if ({prg_done, mem_req, prg_dout} !== {1'b1, 1'b0, 8'h33}) begin
      n_bad++;
      $display("FAIL prg_open_bus: got done=%b req=%b dout=%h required 1 0 33",
               prg_done, mem_req, prg_dout);
    end
    tick();
    n_vec++;
    if ({prg_done, mem_req} !== 2'b00) begin
      n_bad++;
      $display("FAIL prg_open_bus_after: got done,req=%b required 00", {prg_done, mem_req});
    end
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
    prg_aout = 22'h0A0001; chr_aout = 22'h1C0001; prg_read = 1'b1; chr_read = 1'b1;
    tick();
    prg_read = 1'b0; chr_read = 1'b0;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 22'h1C0001}) begin
      n_bad++;
      $display("FAIL rr_first_chr: got req=%b addr=%h required 1 1c0001", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 8'hC1;
    tick();
    mem_ack = 1'b0;
    n_vec++;
    if ({mem_req, chr_done, chr_dout} !== {1'b0, 1'b1, 8'hC1}) begin
      n_bad++;
      $display("FAIL rr_gap: got req=%b done=%b dout=%h required 0 1 c1",
               mem_req, chr_done, chr_dout);
    end
    tick();
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 22'h0A0001}) begin
      n_bad++;
      $display("FAIL rr_second_prg: got req=%b addr=%h required 1 0a0001", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 8'hA1;
    tick();
    mem_ack = 1'b0;
    n_vec++;
    if ({prg_done, prg_dout} !== {1'b1, 8'hA1}) begin
      n_bad++;
      $display("FAIL rr_second_done: got done=%b dout=%h required 1 a1", prg_done, prg_dout);
    end
    tick();
    // A lone CHR grant makes PRG the next contention winner.
    chr_aout = 22'h1C0002; chr_read = 1'b1;
    tick();
    chr_read = 1'b0; mem_ack = 1'b1; mem_rdata = 8'hC2;
    tick();
    mem_ack = 1'b0;
    tick();
    prg_aout = 22'h0A0003; chr_aout = 22'h1C0003; prg_read = 1'b1; chr_read = 1'b1;
    tick();
    prg_read = 1'b0; chr_read = 1'b0;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 22'h0A0003}) begin
      n_bad++;
      $display("FAIL rr_alt_prg: got req=%b addr=%h required 1 0a0003", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 8'hA3;
    tick();
    mem_ack = 1'b0;
    tick();
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 22'h1C0003}) begin
      n_bad++;
      $display("FAIL rr_alt_chr: got req=%b addr=%h required 1 1c0003", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick();
    mem_ack = 1'b0;
    n_vec++;
    if ({chr_done, chr_dout, prg_dout} !== {1'b1, 8'hC3, 8'hA3}) begin
      n_bad++;
      $display("FAIL rr_alt_done: got done=%b chr=%h prg=%h required 1 c3 a3",
               chr_done, chr_dout, prg_dout);
    end
    exp_prg_dout = 8'hA3;
    tick();
  endtask

  task automatic test_overrun();
    logic seen;
    chr_aout = 22'h1C0100; chr_read = 1'b1;
    tick();
    chr_aout = 22'h1C0200;
    tick();
    n_vec++;
    if (err_overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_not_yet: got %b required 0", err_overrun);
    end
    chr_aout = 22'h1C0300;
    tick();
    chr_read = 1'b0;
    n_vec++;
    if ({err_overrun, mem_req, mem_addr} !== {1'b1, 1'b1, 22'h1C0100}) begin
      n_bad++;
      $display("FAIL ovr_flag: got ovr=%b req=%b addr=%h required 1 1 1c0100",
               err_overrun, mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_ack = 1'b0;
    n_vec++;
    if ({chr_done, chr_dout, mem_req} !== {1'b1, 8'h11, 1'b0}) begin
      n_bad++;
      $display("FAIL ovr_first_done: got done=%b dout=%h req=%b required 1 11 0",
               chr_done, chr_dout, mem_req);
    end
    tick();
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 22'h1C0300}) begin
      n_bad++;
      $display("FAIL ovr_third_addr: got req=%b addr=%h required 1 1c0300", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 8'h22;
    tick();
    mem_ack = 1'b0;
    n_vec++;
    if ({chr_done, chr_dout} !== {1'b1, 8'h22}) begin
      n_bad++;
      $display("FAIL ovr_third_done: got done=%b dout=%h required 1 22", chr_done, chr_dout);
    end
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (mem_req) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_second_dropped: got extra req=%b required 0", seen);
    end
  endtask

  task automatic test_timeout();
    int high;
    n_vec++;
    if (err_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_clear: got %b required 0", err_timeout);
    end
    prg_aout = 22'h0A0F00; prg_read = 1'b1;
    tick();
    prg_read = 1'b0;
    high = 0;
    while (mem_req && high < 300) begin
      high++;
      tick();
    end
    n_vec++;
    if (high !== 255) begin
      n_bad++;
      $display("FAIL tmo_length: got %0d cycles of req required 255", high);
    end
    n_vec++;
    if ({mem_req, err_timeout, prg_done, prg_dout} !== {1'b0, 1'b1, 1'b1, exp_prg_dout}) begin
      n_bad++;
      $display("FAIL tmo_abort: got req=%b err=%b done=%b dout=%h required 0 1 1 %h",
               mem_req, err_timeout, prg_done, prg_dout, exp_prg_dout);
    end
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    n_vec++;
    if ({prg_done, chr_done, mem_req, prg_dout} !== {3'b000, exp_prg_dout}) begin
      n_bad++;
      $display("FAIL tmo_late_ack: got done=%b,%b req=%b dout=%h required 0 0 0 %h",
               prg_done, chr_done, mem_req, prg_dout, exp_prg_dout);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen;
    chr_aout = 22'h1C0555; chr_read = 1'b1;
    tick();
    chr_read = 1'b0; prg_aout = 22'h0A0555; prg_read = 1'b1;
    tick();
    prg_read = 1'b0;
    n_vec++;
    if ({mem_req, err_overrun, err_timeout} !== 3'b111) begin
      n_bad++;
      $display("FAIL rst_pre: got req,ovr,tmo=%b required 111", {mem_req, err_overrun, err_timeout});
    end
    #3;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({mem_req, err_overrun, err_timeout} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_async: got req,ovr,tmo=%b required 000", {mem_req, err_overrun, err_timeout});
    end
    tick();
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (prg_done || chr_done || mem_req) seen = 1'b1;
    end
    n_vec++;
    if ({seen, prg_dout, chr_dout} !== 17'd0) begin
      n_bad++;
      $display("FAIL rst_quiet: got activity=%b prg=%h chr=%h required 0 00 00",
               seen, prg_dout, chr_dout);
    end
    prg_aout = 22'h0A0777; prg_read = 1'b1;
    tick();
    prg_read = 1'b0;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 22'h0A0777}) begin
      n_bad++;
      $display("FAIL rst_fresh_req: got req=%b addr=%h required 1 0a0777", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    n_vec++;
    if ({prg_done, prg_dout, mem_req} !== {1'b1, 8'h77, 1'b0}) begin
      n_bad++;
      $display("FAIL rst_fresh_done: got done=%b dout=%h req=%b required 1 77 0",
               prg_done, prg_dout, mem_req);
    end
    tick();
  endtask

  initial begin
    prg_read = 1'b0; prg_write = 1'b0; prg_allow = 1'b1; prg_aout = '0; prg_din = '0;
    chr_read = 1'b0; chr_write = 1'b0; chr_allow = 1'b1; chr_aout = '0; chr_din = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_prg_dout = '0;
    #1;
    reset = 1'b1;
    test_reset();
    test_prg_read();
    test_prg_write();
    test_disallowed();
    test_round_robin();
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
